// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst drainer slice.
// Contents:
//   drain_state_t   - drainer FSM states (IDLE, BURST, FLUSH)
//   DEF_DATA_WIDTH  - default width of FIFO words
//   DEF_COUNT_WIDTH - default width of the FIFO occupancy count
//   max_int         - elaboration-time helper used to size comparators
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_COUNT_WIDTH = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry output buffer between the FIFO read port and the master stream.
// Words pushed in arrive one cycle after the FIFO pop; the head entry drives the
// stream and only advances on a valid/ready handshake, so the presented word is
// held stable while the sink stalls. Occupancy is reported so the parent can
// throttle pops and never overrun the two entries.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the buffer)
//   in_valid   - push in_data this cycle
//   in_data    - word to store
//   out_valid  - head entry is valid
//   out_ready  - sink accepts the head entry
//   out_data   - head entry
//   occ        - number of stored entries (0..2)
module fifo_drain_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  pop;

  assign out_valid = (occ != 2'd0);
  assign out_data  = data0;
  assign pop       = out_valid & out_ready;

  // data0 is always the head. A push lands in the first free slot; a pop shifts
  // data1 forward. A simultaneous push and pop keeps the occupancy unchanged.
  // The parent never pushes into a full buffer without a pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= 2'd0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (occ != 2'd2) begin
            if (occ == 2'd0) begin
              data0 <= in_data;
            end else begin
              data1 <= in_data;
            end
            occ <= occ + 2'd1;
          end
        end
        2'b01: begin
          data0 <= data1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            data0 <= in_data;
          end else begin
            data0 <= data1;
            data1 <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_drainer.sv
// Downstream consumer of the circular FIFO. Watches the FIFO occupancy, pops
// words in bursts of BURST_LEN and presents them on a valid/ready master stream
// with an end-of-burst flag. A partial burst is flushed after TIMEOUT_CYCLES
// idle cycles so stragglers never sit in the FIFO. Pops are throttled so the
// FIFO never sees a read while empty and the output buffer never overflows.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   fifo_rd_en    - pop request to the FIFO
//   fifo_rd_data  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty    - FIFO empty flag
//   fifo_count    - FIFO occupancy
//   m_valid       - output word valid
//   m_ready       - sink accepts the word
//   m_data        - output word
//   m_last        - final word of the current burst
//   burst_active  - a burst or flush is in progress
//   bursts_done   - completed-burst counter, wraps at 2^16
module fifo_burst_drainer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   burst_active,
  output logic [15:0]            bursts_done
);

  localparam int LEN_W   = $clog2(BURST_LEN + 1);
  localparam int CMP_W   = max_int(COUNT_WIDTH, LEN_W);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CMP_W-1:0]   BURST_LEN_CMP = CMP_W'(BURST_LEN);
  localparam logic [LEN_W-1:0]   BURST_LEN_L   = LEN_W'(BURST_LEN);
  localparam logic [TIMER_W-1:0] TIMEOUT_T     = TIMER_W'(TIMEOUT_CYCLES);

  drain_state_t       state;
  drain_state_t       state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [LEN_W-1:0]   pops_left;
  logic [LEN_W-1:0]   pops_next;
  logic [LEN_W-1:0]   beats_left;
  logic [LEN_W-1:0]   beats_next;
  logic               inflight;
  logic [1:0]         buf_occ;
  logic [2:0]         occ_after;
  logic [CMP_W-1:0]   count_ext;
  logic               beat;
  logic               last_beat;

  assign count_ext    = CMP_W'(fifo_count);
  assign beat         = m_valid & m_ready;
  assign m_last       = m_valid && (beats_left == LEN_W'(1));
  assign last_beat    = beat & m_last;
  assign burst_active = (state != IDLE);

  // Buffer slots that stay committed after this cycle: stored words plus the
  // word already on its way from the FIFO, minus the one leaving on a handshake.
  // A new pop is only allowed while that leaves a free slot, which still gives
  // one word per cycle when the sink is always ready.
  assign occ_after  = {1'b0, buf_occ} + {2'b00, inflight} - {2'b00, beat};
  assign fifo_rd_en = !rst && (state != IDLE) && (pops_left != '0) &&
                      !fifo_empty && (occ_after < 3'd2);

  // Next-state logic. In IDLE a full burst takes priority over the idle timer;
  // the timer only runs while stragglers sit in the FIFO and the flush length is
  // the occupancy at the moment the timer expires (always below BURST_LEN there).
  always_comb begin
    state_next = state;
    timer_next = timer;
    pops_next  = pops_left;
    beats_next = beats_left;
    if (fifo_rd_en) begin
      pops_next = pops_left - LEN_W'(1);
    end
    if (beat) begin
      beats_next = beats_left - LEN_W'(1);
    end
    case (state)
      IDLE: begin
        if (count_ext >= BURST_LEN_CMP) begin
          state_next = BURST;
          pops_next  = BURST_LEN_L;
          beats_next = BURST_LEN_L;
          timer_next = '0;
        end else if (count_ext != '0) begin
          if (timer == TIMEOUT_T) begin
            state_next = FLUSH;
            pops_next  = count_ext[LEN_W-1:0];
            beats_next = count_ext[LEN_W-1:0];
            timer_next = '0;
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end else begin
          timer_next = '0;
        end
      end
      BURST, FLUSH: begin
        if (last_beat) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and in-flight tracking. A word popped just before reset is
  // dropped because the in-flight flag and the buffer are cleared together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      pops_left   <= '0;
      beats_left  <= '0;
      inflight    <= 1'b0;
      bursts_done <= 16'd0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      pops_left  <= pops_next;
      beats_left <= beats_next;
      inflight   <= fifo_rd_en;
      if (last_beat) begin
        bursts_done <= bursts_done + 16'd1;
      end
    end
  end

  fifo_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inflight),
    .in_data  (fifo_rd_data),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .occ      (buf_occ)
  );

endmodule

// File: tb/tb_fifo_burst_drainer.sv
// Self-checking bench for fifo_burst_drainer. A behavioural FIFO feeds the
// drainer; every written word is also pushed into a scoreboard together with the
// m_last flag it must carry, and each accepted output beat is popped and compared.
module tb_fifo_burst_drainer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_count = 16'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;
  logic        burst_active;
  logic [15:0] bursts_done;

  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'd0;
  logic        underflow_err = 1'b0;

  logic [15:0] mem_q[$];
  logic [15:0] wr_q[$];
  logic [15:0] exp_data[$];
  logic        exp_last[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  bit rst_req = 1'b1;

  int first_active, first_valid, first_beat, last_beat_cyc;
  int beats, valid_seen, active_seen;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_drainer dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_count  (fifo_count),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .burst_active(burst_active),
    .bursts_done (bursts_done)
  );

  // Registered FIFO model: read data, count and empty all update on the edge.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (mem_q.size() == 0) begin
        underflow_err <= 1'b1;
      end else begin
        fifo_rd_data <= mem_q.pop_front();
      end
    end
    if (wr_en) begin
      mem_q.push_back(wr_data);
    end
    fifo_count <= 16'(mem_q.size());
    fifo_empty <= (mem_q.size() == 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Queue n words for writing and record the expected stream for them.
  task automatic applyStimulus(input logic [15:0] base, input int n, input int burst);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back(base + 16'(i));
      exp_data.push_back(base + 16'(i));
      exp_last.push_back(((i + 1) % burst == 0) || (i == n - 1));
    end
  endtask

  task automatic reset_trackers();
    first_active  = -1;
    first_valid   = -1;
    first_beat    = -1;
    last_beat_cyc = -1;
    beats         = 0;
    valid_seen    = 0;
    active_seen   = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, then sample 1ns later.
  task automatic step_cycle();
    logic [15:0] ed;
    logic        el;
    @(negedge clk);
    rst = rst_req;
    if (wr_q.size() != 0) begin
      wr_en   = 1'b1;
      wr_data = wr_q.pop_front();
    end else begin
      wr_en = 1'b0;
    end
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 2) == 1);
      default: m_ready = 1'b0;
    endcase
    cyc++;
    #1;
    checkOutput("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
    if (prev_stall && !rst) begin
      checkOutput("stall_valid_held", {31'd0, m_valid}, 32'd1);
      checkOutput("stall_data_stable", {16'd0, m_data}, {16'd0, prev_data});
      checkOutput("stall_last_stable", {31'd0, m_last}, {31'd0, prev_last});
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = m_data;
    prev_last  = m_last;
    if (burst_active) active_seen++;
    if (m_valid) valid_seen++;
    if (burst_active && first_active < 0) first_active = cyc;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (!rst && m_valid && m_ready) begin
      beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat_cyc = cyc;
      if (exp_data.size() == 0) begin
        checkOutput("unexpected_beat", {16'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        ed = exp_data.pop_front();
        el = exp_last.pop_front();
        checkOutput("beat_data", {16'd0, m_data}, {16'd0, ed});
        checkOutput("beat_last", {31'd0, m_last}, {31'd0, el});
      end
    end
  endtask

  // Run until every expected word has been delivered and the drainer is idle.
  task automatic drain_all(input int budget);
    int n;
    n = 0;
    while ((exp_data.size() != 0 || burst_active || wr_q.size() != 0) && n < budget) begin
      step_cycle();
      n++;
    end
    checkOutput("drain_pending_words", exp_data.size(), 32'd0);
    checkOutput("drain_idle", {31'd0, burst_active}, 32'd0);
  endtask

  initial begin
    int n;
    $display("[TB] fifo_burst_drainer bench start");
    reset_trackers();

    rst_req = 1'b1;
    repeat (3) step_cycle();
    checkOutput("reset_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("reset_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("reset_m_data", {16'd0, m_data}, 32'd0);
    checkOutput("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("reset_burst_active", {31'd0, burst_active}, 32'd0);
    checkOutput("reset_bursts_done", {16'd0, bursts_done}, 32'd0);
    rst_req = 1'b0;

    $display("[TB] full burst, sink always ready");
    ready_mode = 0;
    reset_trackers();
    applyStimulus(16'h00A0, 8, 8);
    drain_all(80);
    checkOutput("t1_valid_latency", first_valid - first_active, 32'd2);
    checkOutput("t1_back_to_back", last_beat_cyc - first_beat, 32'd7);
    checkOutput("t1_beats", beats, 32'd8);
    checkOutput("t1_bursts_done", {16'd0, bursts_done}, 32'd1);
    checkOutput("t1_fifo_count", {16'd0, fifo_count}, 32'd0);

    $display("[TB] two bursts, sink toggling");
    ready_mode = 1;
    reset_trackers();
    applyStimulus(16'h00C0, 16, 8);
    drain_all(200);
    checkOutput("t2_beats", beats, 32'd16);
    checkOutput("t2_bursts_done", {16'd0, bursts_done}, 32'd3);
    checkOutput("t2_fifo_count", {16'd0, fifo_count}, 32'd0);

    $display("[TB] partial burst flushed on timeout");
    ready_mode = 0;
    reset_trackers();
    applyStimulus(16'h00B0, 3, 8);
    while (wr_q.size() != 0) step_cycle();
    repeat (32) step_cycle();
    checkOutput("t3_no_early_valid", valid_seen, 32'd0);
    drain_all(100);
    checkOutput("t3_beats", beats, 32'd3);
    checkOutput("t3_bursts_done", {16'd0, bursts_done}, 32'd4);

    $display("[TB] long empty period then stragglers");
    reset_trackers();
    repeat (100) step_cycle();
    checkOutput("t4_idle_no_burst", active_seen, 32'd0);
    applyStimulus(16'h00D0, 7, 8);
    drain_all(150);
    checkOutput("t4_beats", beats, 32'd7);
    checkOutput("t4_bursts_done", {16'd0, bursts_done}, 32'd5);
    checkOutput("t4_fifo_count", {16'd0, fifo_count}, 32'd0);
    checkOutput("t4_underflow", {31'd0, underflow_err}, 32'd0);

    $display("[TB] reset in the middle of a burst");
    reset_trackers();
    applyStimulus(16'h00E0, 8, 8);
    n = 0;
    while (beats < 3 && n < 60) begin
      step_cycle();
      n++;
    end
    checkOutput("t5_three_beats", beats, 32'd3);
    rst_req = 1'b1;
    step_cycle();
    rst_req = 1'b0;
    exp_data.delete();
    exp_last.delete();
    prev_stall = 1'b0;
    step_cycle();
    checkOutput("t5_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("t5_burst_active", {31'd0, burst_active}, 32'd0);
    checkOutput("t5_bursts_done", {16'd0, bursts_done}, 32'd0);
    // Three beats delivered, one word buffered and one in flight were popped.
    checkOutput("t5_fifo_count", {16'd0, fifo_count}, 32'd3);
    exp_data.push_back(16'h00E5);
    exp_last.push_back(1'b0);
    exp_data.push_back(16'h00E6);
    exp_last.push_back(1'b0);
    exp_data.push_back(16'h00E7);
    exp_last.push_back(1'b1);
    reset_trackers();
    drain_all(100);
    checkOutput("t5_restart_beats", beats, 32'd3);
    checkOutput("t5_restart_bursts_done", {16'd0, bursts_done}, 32'd1);
    checkOutput("t5_underflow", {31'd0, underflow_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
